// File: rtl/ycbcr2rgb_pkg.sv
// Shared constants and helpers for the 4:2:2 YCbCr to RGB888 converter.
// Define YCBCR_VIDEO_RANGE_EN to select limited-range (studio swing) coefficients.
package ycbcr2rgb_pkg;

    localparam int FRAC       = 8;
    localparam int ACC_W      = 19;
    localparam int PROD_W     = 18;
    localparam int PIPE_DEPTH = 4;

    localparam logic [7:0]              CHROMA_MID = 8'd128;
    localparam logic signed [ACC_W-1:0] ROUND_HALF = 19'sd128;

    localparam logic signed [PROD_W-1:0] FULL_K_R_CR = 18'sd359;
    localparam logic signed [PROD_W-1:0] FULL_K_G_CB = 18'sd88;
    localparam logic signed [PROD_W-1:0] FULL_K_G_CR = 18'sd183;
    localparam logic signed [PROD_W-1:0] FULL_K_B_CB = 18'sd454;

    localparam logic signed [PROD_W-1:0] VID_K_R_CR  = 18'sd409;
    localparam logic signed [PROD_W-1:0] VID_K_G_CB  = 18'sd100;
    localparam logic signed [PROD_W-1:0] VID_K_G_CR  = 18'sd208;
    localparam logic signed [PROD_W-1:0] VID_K_B_CB  = 18'sd516;
    localparam logic signed [ACC_W-1:0]  VID_K_Y     = 19'sd298;
    localparam logic signed [ACC_W-1:0]  VID_Y_OFS   = 19'sd16;

`ifdef YCBCR_VIDEO_RANGE_EN
    localparam logic signed [PROD_W-1:0] K_R_CR = VID_K_R_CR;
    localparam logic signed [PROD_W-1:0] K_G_CB = VID_K_G_CB;
    localparam logic signed [PROD_W-1:0] K_G_CR = VID_K_G_CR;
    localparam logic signed [PROD_W-1:0] K_B_CB = VID_K_B_CB;
`else
    localparam logic signed [PROD_W-1:0] K_R_CR = FULL_K_R_CR;
    localparam logic signed [PROD_W-1:0] K_G_CB = FULL_K_G_CB;
    localparam logic signed [PROD_W-1:0] K_G_CR = FULL_K_G_CR;
    localparam logic signed [PROD_W-1:0] K_B_CB = FULL_K_B_CB;
`endif

    function automatic logic [7:0] clamp_u8(input logic signed [ACC_W-1:0] v);
        logic [7:0] r;
        if (v < 19'sd0) begin
            r = 8'd0;
        end else if (v > 19'sd255) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/chroma422_pair.sv
// Stage 0: pairs the interleaved Cb/Cr samples of a 4:2:2 stream so every
// pixel leaves with a full {Y, Cb, Cr}; an active sync restarts the pairing.
module chroma422_pair
    import ycbcr2rgb_pkg::*;
#(
    parameter logic SYNC_ACT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_ycc,
    input  logic        i_valid,
    input  logic        i_hsync,
    input  logic        i_vsync,
    output logic [7:0]  o_y,
    output logic [7:0]  o_cb,
    output logic [7:0]  o_cr,
    output logic        o_valid
);

    logic       phase_q, phase_d;
    logic [7:0] held_cb_q, held_cb_d;
    logic [7:0] held_cr_q, held_cr_d;
    logic [7:0] y_q, y_d;
    logic [7:0] cb_q, cb_d;
    logic [7:0] cr_q, cr_d;
    logic       valid_q, valid_d;

    logic       sync_hit_s;
    logic       phase_eff_s;
    logic [7:0] held_cb_eff_s;
    logic [7:0] held_cr_eff_s;
    logic [7:0] c_s;

    // Pairing state: a sync clears first, then a coincident beat is processed as phase 0.
    always_comb begin
        sync_hit_s = (i_hsync == SYNC_ACT) || (i_vsync == SYNC_ACT);
        c_s        = i_ycc[7:0];
        if (sync_hit_s) begin
            phase_eff_s   = 1'b0;
            held_cb_eff_s = CHROMA_MID;
            held_cr_eff_s = CHROMA_MID;
        end else begin
            phase_eff_s   = phase_q;
            held_cb_eff_s = held_cb_q;
            held_cr_eff_s = held_cr_q;
        end

        phase_d   = phase_eff_s;
        held_cb_d = held_cb_eff_s;
        held_cr_d = held_cr_eff_s;
        y_d       = i_ycc[15:8];
        cb_d      = held_cb_eff_s;
        cr_d      = held_cr_eff_s;
        valid_d   = i_valid;

        if (i_valid) begin
            if (!phase_eff_s) begin
                cb_d      = c_s;
                held_cb_d = c_s;
            end else begin
                cr_d      = c_s;
                held_cr_d = c_s;
            end
            phase_d = ~phase_eff_s;
        end else begin
            phase_d = phase_eff_s;
        end
    end

    // Stage-0 register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= 1'b0;
            held_cb_q <= CHROMA_MID;
            held_cr_q <= CHROMA_MID;
            y_q       <= 8'd0;
            cb_q      <= 8'd0;
            cr_q      <= 8'd0;
            valid_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            held_cb_q <= held_cb_d;
            held_cr_q <= held_cr_d;
            y_q       <= y_d;
            cb_q      <= cb_d;
            cr_q      <= cr_d;
            valid_q   <= valid_d;
        end
    end

    assign o_y     = y_q;
    assign o_cb    = cb_q;
    assign o_cr    = cr_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/ycbcr422_to_rgb.sv
// BT.601 4:2:2 YCbCr to RGB888 converter, 4-cycle pipeline with matched sync delay.
// Define YCBCR_VIDEO_RANGE_EN for limited-range input scaling.
module ycbcr422_to_rgb
    import ycbcr2rgb_pkg::*;
#(
    parameter logic SYNC_ACT = 1'b1,
    parameter int   LATENCY  = PIPE_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_ycc,
    input  logic        i_valid,
    input  logic        i_hsync,
    input  logic        i_vsync,
    output logic [23:0] o_rgb,
    output logic        o_valid,
    output logic        o_hsync,
    output logic        o_vsync
);

    logic [7:0] y1_s, cb1_s, cr1_s;
    logic       v1_s;

    chroma422_pair #(.SYNC_ACT(SYNC_ACT)) u_pair (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ycc   (i_ycc),
        .i_valid (i_valid),
        .i_hsync (i_hsync),
        .i_vsync (i_vsync),
        .o_y     (y1_s),
        .o_cb    (cb1_s),
        .o_cr    (cr1_s),
        .o_valid (v1_s)
    );

    logic signed [ACC_W-1:0]  yt_q, yt_d;
    logic signed [PROD_W-1:0] p_rcr_q, p_rcr_d;
    logic signed [PROD_W-1:0] p_gcb_q, p_gcb_d;
    logic signed [PROD_W-1:0] p_gcr_q, p_gcr_d;
    logic signed [PROD_W-1:0] p_bcb_q, p_bcb_d;
    logic                     v2_q, v2_d;

    logic signed [ACC_W-1:0]  r3_q, r3_d, g3_q, g3_d, b3_q, b3_d;
    logic                     v3_q, v3_d;

    logic [23:0]              rgb_q, rgb_d;
    logic                     valid_q, valid_d;
    logic [LATENCY-1:0]       hs_q, hs_d, vs_q, vs_d;

    logic signed [8:0]        dcb_s, dcr_s;
    logic signed [PROD_W-1:0] dcb_x_s, dcr_x_s;
    logic signed [ACC_W-1:0]  r_sum_s, g_sum_s, b_sum_s;

    // Chroma offsets and the four chroma products plus the luma term.
    always_comb begin
        dcb_s   = $signed({1'b0, cb1_s}) - $signed({1'b0, CHROMA_MID});
        dcr_s   = $signed({1'b0, cr1_s}) - $signed({1'b0, CHROMA_MID});
        dcb_x_s = $signed({{(PROD_W-9){dcb_s[8]}}, dcb_s});
        dcr_x_s = $signed({{(PROD_W-9){dcr_s[8]}}, dcr_s});
        p_rcr_d = K_R_CR * dcr_x_s;
        p_gcb_d = K_G_CB * dcb_x_s;
        p_gcr_d = K_G_CR * dcr_x_s;
        p_bcb_d = K_B_CB * dcb_x_s;
`ifdef YCBCR_VIDEO_RANGE_EN
        yt_d    = VID_K_Y * ($signed({{(ACC_W-8){1'b0}}, y1_s}) - VID_Y_OFS);
`else
        yt_d    = $signed({{(ACC_W-16){1'b0}}, y1_s, 8'd0});
`endif
        v2_d    = v1_s;
    end

    // Rounded fixed-point sums, scaled back to integer pixel units.
    always_comb begin
        r_sum_s = yt_q + $signed({{(ACC_W-PROD_W){p_rcr_q[PROD_W-1]}}, p_rcr_q}) + ROUND_HALF;
        g_sum_s = yt_q - $signed({{(ACC_W-PROD_W){p_gcb_q[PROD_W-1]}}, p_gcb_q})
                       - $signed({{(ACC_W-PROD_W){p_gcr_q[PROD_W-1]}}, p_gcr_q}) + ROUND_HALF;
        b_sum_s = yt_q + $signed({{(ACC_W-PROD_W){p_bcb_q[PROD_W-1]}}, p_bcb_q}) + ROUND_HALF;
        r3_d    = r_sum_s >>> FRAC;
        g3_d    = g_sum_s >>> FRAC;
        b3_d    = b_sum_s >>> FRAC;
        v3_d    = v2_q;
    end

    // Clamp to 8 bits; idle slots present black so downstream sees clean zeros.
    always_comb begin
        if (v3_q) begin
            rgb_d = {clamp_u8(r3_q), clamp_u8(g3_q), clamp_u8(b3_q)};
        end else begin
            rgb_d = 24'd0;
        end
        valid_d = v3_q;
        hs_d    = {hs_q[LATENCY-2:0], i_hsync};
        vs_d    = {vs_q[LATENCY-2:0], i_vsync};
    end

    // Pipeline registers for stages 2..4 and the sync delay lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yt_q    <= 19'sd0;
            p_rcr_q <= 18'sd0;
            p_gcb_q <= 18'sd0;
            p_gcr_q <= 18'sd0;
            p_bcb_q <= 18'sd0;
            v2_q    <= 1'b0;
            r3_q    <= 19'sd0;
            g3_q    <= 19'sd0;
            b3_q    <= 19'sd0;
            v3_q    <= 1'b0;
            rgb_q   <= 24'd0;
            valid_q <= 1'b0;
            hs_q    <= '0;
            vs_q    <= '0;
        end else begin
            yt_q    <= yt_d;
            p_rcr_q <= p_rcr_d;
            p_gcb_q <= p_gcb_d;
            p_gcr_q <= p_gcr_d;
            p_bcb_q <= p_bcb_d;
            v2_q    <= v2_d;
            r3_q    <= r3_d;
            g3_q    <= g3_d;
            b3_q    <= b3_d;
            v3_q    <= v3_d;
            rgb_q   <= rgb_d;
            valid_q <= valid_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign o_rgb   = rgb_q;
    assign o_valid = valid_q;
    assign o_hsync = hs_q[LATENCY-1];
    assign o_vsync = vs_q[LATENCY-1];

endmodule

// File: tb/tb_ycbcr422_to_rgb.sv
// Randomized self-checking bench: a cycle-indexed table of expected outputs
// built from a plain-arithmetic model, compared every cycle on the falling edge.
module tb_ycbcr422_to_rgb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_ycc = 16'd0;
    logic        i_valid = 1'b0;
    logic        i_hsync = 1'b0;
    logic        i_vsync = 1'b0;
    logic [23:0] o_rgb;
    logic        o_valid, o_hsync, o_vsync;

    ycbcr422_to_rgb dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ycc   (i_ycc),
        .i_valid (i_valid),
        .i_hsync (i_hsync),
        .i_vsync (i_vsync),
        .o_rgb   (o_rgb),
        .o_valid (o_valid),
        .o_hsync (o_hsync),
        .o_vsync (o_vsync)
    );

    always #5 clk = ~clk;

    localparam int DEPTH = 8192;
    int          ecount = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [26:0] exp_out [0:DEPTH-1];
    bit          exp_set [0:DEPTH-1];

    int m_phase = 0;
    int m_cb = 128;
    int m_cr = 128;

    always @(posedge clk) ecount <= ecount + 1;

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic logic [23:0] model_rgb(input int y, input int cb, input int cr);
        int yt, r, g, b, dcb, dcr;
        logic [23:0] res;
        dcb = cb - 128;
        dcr = cr - 128;
`ifdef YCBCR_VIDEO_RANGE_EN
        yt = 298 * (y - 16);
        r = (yt + 409 * dcr + 128) >>> 8;
        g = (yt - 100 * dcb - 208 * dcr + 128) >>> 8;
        b = (yt + 516 * dcb + 128) >>> 8;
`else
        yt = y * 256;
        r = (yt + 359 * dcr + 128) >>> 8;
        g = (yt - 88 * dcb - 183 * dcr + 128) >>> 8;
        b = (yt + 454 * dcb + 128) >>> 8;
`endif
        res[23:16] = 8'(clamp(r));
        res[15:8]  = 8'(clamp(g));
        res[7:0]   = 8'(clamp(b));
        return res;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Drive one input cycle and record what the outputs must be 4 edges later.
    task automatic cyc(input logic rst, input logic v, input logic [7:0] y,
                       input logic [7:0] c, input logic hs, input logic vs);
        int base, cb, cr;
        logic [23:0] rgb;
        rst_n   = rst;
        i_valid = v;
        i_ycc   = {y, c};
        i_hsync = hs;
        i_vsync = vs;
        base    = ecount;
        if (!rst) begin
            m_phase = 0;
            m_cb    = 128;
            m_cr    = 128;
            for (int i = 1; i <= 4; i++) begin
                exp_out[(base + i) % DEPTH] = 27'd0;
                exp_set[(base + i) % DEPTH] = 1'b1;
            end
        end else begin
            if (hs || vs) begin
                m_phase = 0;
                m_cb    = 128;
                m_cr    = 128;
            end
            rgb = 24'd0;
            if (v) begin
                if (m_phase == 0) begin
                    cb   = int'(c);
                    cr   = m_cr;
                    m_cb = int'(c);
                end else begin
                    cb   = m_cb;
                    cr   = int'(c);
                    m_cr = int'(c);
                end
                m_phase = 1 - m_phase;
                rgb = model_rgb(int'(y), cb, cr);
            end
            exp_out[(base + 4) % DEPTH] = {rgb, v, hs, vs};
            exp_set[(base + 4) % DEPTH] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    // Compare every cycle whose expectation has been recorded.
    always @(negedge clk) begin
        if (exp_set[ecount % DEPTH]) begin
            chk("pipe_out", {5'd0, o_rgb, o_valid, o_hsync, o_vsync},
                {5'd0, exp_out[ecount % DEPTH]});
            exp_set[ecount % DEPTH] = 1'b0;
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_set[i] = 1'b0;

`ifndef YCBCR_VIDEO_RANGE_EN
        chk("model_grey",     {8'd0, model_rgb(128, 128, 128)}, 32'h00808080);
        chk("model_white",    {8'd0, model_rgb(255, 128, 128)}, 32'h00FFFFFF);
        chk("model_cr_clamp", {8'd0, model_rgb(255, 128, 255)}, 32'h00FFA4FF);
        chk("model_b_neg",    {8'd0, model_rgb(0, 0, 128)},     32'h00002C00);
`endif

        cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        chk("reset_state", {5'd0, o_rgb, o_valid, o_hsync, o_vsync}, 32'd0);
        idle(2);

        cyc(1'b1, 1'b1, 8'd128, 8'd128, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'd128, 8'd128, 1'b0, 1'b0);
        idle(4);

        cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'd255, 8'd128, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
        idle(3);
`ifndef YCBCR_VIDEO_RANGE_EN
        chk("pix1_cr255", {8'd0, o_rgb}, 32'h00FFA4FF);
`endif
        chk("pix1_valid", {31'd0, o_valid}, 32'd1);
        idle(2);

        cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
        idle(3);
`ifndef YCBCR_VIDEO_RANGE_EN
        chk("pix0_b_clamp", {8'd0, o_rgb}, 32'h00002C00);
`endif
        idle(2);

        cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 8'd90, 8'd40, 1'b0, 1'b0);
        idle(3);
        cyc(1'b1, 1'b1, 8'd150, 8'd220, 1'b0, 1'b0);
        idle(5);

        cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        idle(3);
        chk("hsync_pulse", {29'd0, o_hsync, o_vsync, o_valid}, 32'b100);
        chk("hsync_rgb0", {8'd0, o_rgb}, 32'd0);
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        idle(3);
        chk("vsync_pulse", {29'd0, o_hsync, o_vsync, o_valid}, 32'b010);
        idle(2);

        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'd50, 8'd60, 1'b0, 1'b0);
        chk("rst_flush", {5'd0, o_rgb, o_valid, o_hsync, o_vsync}, 32'd0);
        cyc(1'b1, 1'b1, 8'd128, 8'd200, 1'b0, 1'b0);
        idle(3);
`ifndef YCBCR_VIDEO_RANGE_EN
        chk("post_rst_pix", {8'd0, o_rgb}, 32'h008067FF);
`endif
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 9) < 7),
                8'($urandom), 8'($urandom),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 249) == 0));
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
